// File: rtl/pulse_meas.sv
// Measures high time and period of a signal from upstream re/fe pulses; one result per period.
// Latency: result valid one cycle after the closing rising edge. Backpressure: one-deep result
// register, newer results dropped (sticky ovr_o) while unaccepted. Optional watchdog: PULSE_MEAS_TIMEOUT_EN.
module pulse_meas #(
    parameter int CNT_WIDTH = 16,
    parameter int TIMEOUT   = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 re_i,
    input  logic                 fe_i,
    output logic [CNT_WIDTH-1:0] high_o,
    output logic [CNT_WIDTH-1:0] period_o,
    output logic                 sat_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 ovr_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt_p, cnt_h, cnt_p_nxt, cnt_h_nxt;
    logic [CNT_WIDTH-1:0] p_inc, h_inc;
    logic                 p_max, h_max;
    logic                 meas_sat, meas_sat_nxt;
    logic                 close;
    logic                 re_v, fe_v;
    logic                 edge_acc;
    logic                 wd_hit;

    // Coincident edges carry no usable ordering, so both are dropped.
    assign re_v = re_i & ~fe_i;
    assign fe_v = fe_i & ~re_i;

    assign p_max = (cnt_p == CNT_MAX);
    assign h_max = (cnt_h == CNT_MAX);
    assign p_inc = p_max ? cnt_p : cnt_p + 1'b1;
    assign h_inc = h_max ? cnt_h : cnt_h + 1'b1;

    assign edge_acc = re_v | ((state == HIGH) & fe_v);

    always_comb begin
        state_nxt    = state;
        cnt_p_nxt    = cnt_p;
        cnt_h_nxt    = cnt_h;
        meas_sat_nxt = meas_sat;
        close        = 1'b0;
        if (!en_i) begin
            state_nxt    = IDLE;
            cnt_p_nxt    = '0;
            cnt_h_nxt    = '0;
            meas_sat_nxt = 1'b0;
        end else if (wd_hit) begin
            state_nxt    = ARM;
            cnt_p_nxt    = '0;
            cnt_h_nxt    = '0;
            meas_sat_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: state_nxt = ARM;
                ARM: begin
                    if (re_v) begin
                        state_nxt    = HIGH;
                        cnt_p_nxt    = '0;
                        cnt_h_nxt    = '0;
                        meas_sat_nxt = 1'b0;
                    end
                end
                HIGH: begin
                    if (re_v) begin
                        // Missed falling edge: restart the measurement from this edge.
                        cnt_p_nxt    = '0;
                        cnt_h_nxt    = '0;
                        meas_sat_nxt = 1'b0;
                    end else begin
                        cnt_p_nxt    = p_inc;
                        cnt_h_nxt    = h_inc;
                        meas_sat_nxt = meas_sat | p_max | h_max;
                        if (fe_v)
                            state_nxt = LOW;
                    end
                end
                LOW: begin
                    if (re_v) begin
                        close        = 1'b1;
                        state_nxt    = HIGH;
                        cnt_p_nxt    = '0;
                        cnt_h_nxt    = '0;
                        meas_sat_nxt = 1'b0;
                    end else begin
                        cnt_p_nxt    = p_inc;
                        meas_sat_nxt = meas_sat | p_max;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            cnt_p    <= '0;
            cnt_h    <= '0;
            meas_sat <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_p    <= cnt_p_nxt;
            cnt_h    <= cnt_h_nxt;
            meas_sat <= meas_sat_nxt;
            busy_o   <= (state_nxt != IDLE);
        end
    end

    // The closing cycle's own count is folded in here, so period = t1 - t0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            high_o   <= '0;
            period_o <= '0;
            sat_o    <= 1'b0;
            valid_o  <= 1'b0;
            ovr_o    <= 1'b0;
        end else begin
            if (close && (!valid_o || ready_i)) begin
                high_o   <= cnt_h;
                period_o <= p_inc;
                sat_o    <= meas_sat | p_max;
                valid_o  <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (close && valid_o && !ready_i)
                ovr_o <= 1'b1;
        end
    end

`ifdef PULSE_MEAS_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd;
    logic            timeout_q;

    assign wd_hit = en_i && ((state == HIGH) || (state == LOW)) && !edge_acc
                    && (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd        <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (en_i && ((state == HIGH) || (state == LOW)) && !edge_acc && !wd_hit)
                wd <= wd + 1'b1;
            else
                wd <= '0;
            if (wd_hit)
                timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0) | edge_acc;
    assign wd_hit         = 1'b0;
    assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_meas.sv
// Directed bench for pulse_meas (CNT_WIDTH = 4, TIMEOUT = 8); cycle 0 is the first cycle after reset.
module tb_pulse_meas;

    logic       clk = 1'b0;
    logic       rst_i, en_i, re_i, fe_i, ready_i;
    logic [3:0] high_o, period_o;
    logic       sat_o, valid_o, ovr_o, busy_o, timeout_o;

    int pass_cnt = 0;
    int total    = 0;
    int cyc      = 0;
    int re_list[$];
    int fe_list[$];

    pulse_meas #(.CNT_WIDTH(4), .TIMEOUT(8)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .re_i      (re_i),
        .fe_i      (fe_i),
        .high_o    (high_o),
        .period_o  (period_o),
        .sat_o     (sat_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .ovr_o     (ovr_o),
        .busy_o    (busy_o),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1);
    end

    // Drives cycles cyc..target-1; afterwards outputs reflect "cycle target".
    task automatic run_until(input int target);
        while (cyc < target) begin
            re_i = 1'b0;
            fe_i = 1'b0;
            foreach (re_list[i]) if (re_list[i] == cyc) re_i = 1'b1;
            foreach (fe_list[i]) if (fe_list[i] == cyc) fe_i = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        re_i = 1'b0;
        fe_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i   = 1'b1;
        en_i    = 1'b0;
        re_i    = 1'b0;
        fe_i    = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        cyc   = 0;
        re_list.delete();
        fe_list.delete();
    endtask

    task automatic test_reset();
        rst_i   = 1'b1;
        en_i    = 1'b1;
        re_i    = 1'b1;
        fe_i    = 1'b0;
        ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        re_i  = 1'b0;
        cyc   = 0;
        re_list.delete();
        fe_list.delete();
        total++;
        if ({high_o, period_o, sat_o, valid_o, ovr_o, busy_o, timeout_o} !== 13'd0)
            $display("FAIL reset_outputs: got %b expected 0",
                     {high_o, period_o, sat_o, valid_o, ovr_o, busy_o, timeout_o});
        else pass_cnt++;
        run_until(2);
        total++;
        if (busy_o !== 1'b1) $display("FAIL reset_busy_after_en: got %b expected 1", busy_o);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        do_reset();
        en_i    = 1'b1;
        ready_i = 1'b1;
        re_list = '{10, 20};
        fe_list = '{13};
        run_until(20);
        total++;
        if (valid_o !== 1'b0) $display("FAIL basic_no_early_valid: got %b expected 0", valid_o);
        else pass_cnt++;
        run_until(21);
        total++;
        if ({valid_o, high_o, period_o, sat_o} !== {1'b1, 4'd3, 4'd10, 1'b0})
            $display("FAIL basic_result: got v=%b h=%0d p=%0d s=%b expected v=1 h=3 p=10 s=0",
                     valid_o, high_o, period_o, sat_o);
        else pass_cnt++;
        run_until(22);
        total++;
        if (valid_o !== 1'b0) $display("FAIL basic_valid_one_cycle: got %b expected 0", valid_o);
        else pass_cnt++;
    endtask

    // Continues the basic waveform: fe 25, re 30, fe 33, re 35, ready low 22..39.
    task automatic test_back_to_back();
        re_list.push_back(30);
        re_list.push_back(35);
        fe_list.push_back(25);
        fe_list.push_back(33);
        ready_i = 1'b0;
        run_until(31);
        total++;
        if ({valid_o, high_o, period_o, sat_o} !== {1'b1, 4'd5, 4'd10, 1'b0})
            $display("FAIL b2b_second_result: got v=%b h=%0d p=%0d s=%b expected v=1 h=5 p=10 s=0",
                     valid_o, high_o, period_o, sat_o);
        else pass_cnt++;
        run_until(35);
        total++;
        if (ovr_o !== 1'b0) $display("FAIL b2b_no_early_ovr: got %b expected 0", ovr_o);
        else pass_cnt++;
        run_until(36);
        total++;
        if ({ovr_o, valid_o, high_o, period_o} !== {1'b1, 1'b1, 4'd5, 4'd10})
            $display("FAIL b2b_overrun: got o=%b v=%b h=%0d p=%0d expected o=1 v=1 h=5 p=10",
                     ovr_o, valid_o, high_o, period_o);
        else pass_cnt++;
        run_until(40);
        total++;
        if ({valid_o, high_o, period_o} !== {1'b1, 4'd5, 4'd10})
            $display("FAIL b2b_held: got v=%b h=%0d p=%0d expected v=1 h=5 p=10",
                     valid_o, high_o, period_o);
        else pass_cnt++;
        ready_i = 1'b1;
        run_until(41);
        total++;
        if ({valid_o, ovr_o} !== 2'b01)
            $display("FAIL b2b_accepted: got v=%b o=%b expected v=0 o=1", valid_o, ovr_o);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_reset();
        en_i    = 1'b1;
        ready_i = 1'b1;
        re_list = '{2, 32, 40};
        fe_list = '{22, 35};
        run_until(33);
        total++;
        if ({valid_o, high_o, period_o, sat_o} !== {1'b1, 4'd15, 4'd15, 1'b1})
            $display("FAIL sat_result: got v=%b h=%0d p=%0d s=%b expected v=1 h=15 p=15 s=1",
                     valid_o, high_o, period_o, sat_o);
        else pass_cnt++;
        run_until(41);
        total++;
        if ({valid_o, high_o, period_o, sat_o} !== {1'b1, 4'd3, 4'd8, 1'b0})
            $display("FAIL sat_cleared_next: got v=%b h=%0d p=%0d s=%b expected v=1 h=3 p=8 s=0",
                     valid_o, high_o, period_o, sat_o);
        else pass_cnt++;
    endtask

    task automatic test_edge_anomalies();
        do_reset();
        en_i    = 1'b1;
        ready_i = 1'b1;
        re_list = '{5, 10, 14, 17, 20};
        fe_list = '{3, 5, 16, 17};
        run_until(11);
        total++;
        if ({valid_o, busy_o} !== 2'b01)
            $display("FAIL anom_fe_in_arm: got v=%b b=%b expected v=0 b=1", valid_o, busy_o);
        else pass_cnt++;
        run_until(18);
        total++;
        if (valid_o !== 1'b0) $display("FAIL anom_simultaneous: got v=%b expected 0", valid_o);
        else pass_cnt++;
        run_until(21);
        total++;
        if ({valid_o, high_o, period_o, sat_o} !== {1'b1, 4'd2, 4'd6, 1'b0})
            $display("FAIL anom_restart: got v=%b h=%0d p=%0d s=%b expected v=1 h=2 p=6 s=0",
                     valid_o, high_o, period_o, sat_o);
        else pass_cnt++;
    endtask

    task automatic test_disable_reset();
        do_reset();
        en_i    = 1'b1;
        ready_i = 1'b0;
        re_list = '{2, 8, 10};
        fe_list = '{4, 9};
        run_until(9);
        total++;
        if ({valid_o, high_o, period_o} !== {1'b1, 4'd2, 4'd6})
            $display("FAIL dis_pending: got v=%b h=%0d p=%0d expected v=1 h=2 p=6",
                     valid_o, high_o, period_o);
        else pass_cnt++;
        run_until(11);
        en_i = 1'b0;
        run_until(12);
        total++;
        if ({busy_o, valid_o, ovr_o, high_o, period_o} !== {1'b0, 1'b1, 1'b1, 4'd2, 4'd6})
            $display("FAIL dis_idle_retain: got b=%b v=%b o=%b h=%0d p=%0d expected b=0 v=1 o=1 h=2 p=6",
                     busy_o, valid_o, ovr_o, high_o, period_o);
        else pass_cnt++;
        rst_i = 1'b1;
        en_i  = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        total++;
        if ({high_o, period_o, sat_o, valid_o, ovr_o, busy_o, timeout_o} !== 13'd0)
            $display("FAIL dis_reset_clears: got %b expected 0",
                     {high_o, period_o, sat_o, valid_o, ovr_o, busy_o, timeout_o});
        else pass_cnt++;
    endtask

`ifdef PULSE_MEAS_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        en_i    = 1'b1;
        ready_i = 1'b1;
        re_list = '{5, 16, 21};
        fe_list = '{18};
        run_until(14);
        total++;
        if ({timeout_o, valid_o, busy_o} !== 3'b101)
            $display("FAIL timeout_fire: got t=%b v=%b b=%b expected t=1 v=0 b=1",
                     timeout_o, valid_o, busy_o);
        else pass_cnt++;
        run_until(22);
        total++;
        if ({valid_o, high_o, period_o, timeout_o} !== {1'b1, 4'd2, 4'd5, 1'b1})
            $display("FAIL timeout_recover: got v=%b h=%0d p=%0d t=%b expected v=1 h=2 p=5 t=1",
                     valid_o, high_o, period_o, timeout_o);
        else pass_cnt++;
    endtask
`endif

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b0;
        re_i    = 1'b0;
        fe_i    = 1'b0;
        ready_i = 1'b1;
        test_reset();
        test_basic();
        test_back_to_back();
`ifndef PULSE_MEAS_TIMEOUT_EN
        test_saturation();
`endif
        test_edge_anomalies();
        test_disable_reset();
`ifdef PULSE_MEAS_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
